pipe_hazard_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipelined RISC-V core (IF/ID/EX/MEM/WB).
- Successor to the single-cycle datapath control; parametrised in register-address width, branch penalty and counter width.
- Keeps an internal shadow pipeline of destination-register info for the EX, MEM and WB slots.
- Generates ALU operand forwarding selects, load-use stalls, branch flushes and saturating stall/flush performance counters.

---
 rtl/pipe_hazard_unit.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - hazard detection, operand forwarding and flush control for a 5-stage pipeline
module pipe_hazard_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [1:0]       FLUSH_RELOAD = 2'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  // Shadow destination info for the EX, MEM and WB slots
  logic                  ex_valid, mem_valid, wb_valid;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic                  ex_reg_write, mem_reg_write, wb_reg_write;
  logic                  ex_mem_read, mem_mem_read, wb_mem_read;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  logic                  ex_uses_rs1, ex_uses_rs2;

  // Remaining flush cycles after the branch cycle itself
  logic [1:0] flush_cnt;

  logic branch;
  logic flush_active;
  logic load_use;
  logic ex_bubble;

  // Nearest older producer wins; x0 never forwards
  function automatic logic [1:0] fwd_select(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  m_valid,
    input logic                  m_wr,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  w_valid,
    input logic                  w_wr,
    input logic [REG_ADDR_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && m_valid && m_wr && (m_rd != '0) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (uses && w_valid && w_wr && (w_rd != '0) && (w_rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard decisions; branch and ID inputs are ignored while reset is held
  always_comb begin
    branch       = ex_branch_taken & ~reset;
    flush_active = branch | ((flush_cnt != 2'd0) & ~reset);
    load_use     = ~reset & id_valid & ex_valid & ex_mem_read & ex_reg_write &
                   (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    flush_if_id  = flush_active;
    stall_if_id  = load_use & ~flush_active;
    bubble_id_ex = flush_active | load_use;
    ex_bubble    = bubble_id_ex | ~id_valid;
  end

  // Forward selects come from registered slot state only
  always_comb begin
    fwd_a_sel = fwd_select(ex_valid & ex_uses_rs1, ex_rs1, mem_valid, mem_reg_write, mem_rd,
                           wb_valid, wb_reg_write, wb_rd);
    fwd_b_sel = fwd_select(ex_valid & ex_uses_rs2, ex_rs2, mem_valid, mem_reg_write, mem_rd,
                           wb_valid, wb_reg_write, wb_rd);
  end

  // Advance the shadow slots every cycle, inserting a bubble into EX when needed
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_uses_rs1   <= 1'b0;
      ex_uses_rs2   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_read   <= 1'b0;
    end else begin
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      wb_mem_read   <= mem_mem_read;
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      if (ex_bubble) begin
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_uses_rs1  <= 1'b0;
        ex_uses_rs2  <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_uses_rs1  <= id_uses_rs1;
        ex_uses_rs2  <= id_uses_rs2;
      end
    end
  end

  // Flush window counter; a new taken branch restarts the window
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= 2'd0;
    end else if (branch) begin
      flush_cnt <= FLUSH_RELOAD;
    end else if (flush_cnt != 2'd0) begin
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if_id && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (branch && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit against an instruction-level model
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic       ex_branch_taken;

  logic        s0, b0, f0, s1, b1, f1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_ADDR_W(5), .BRANCH_PENALTY(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if_id(s0), .bubble_id_ex(b0), .flush_if_id(f0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
    .stall_count(sc0), .flush_count(fc0)
  );

  pipe_hazard_unit #(.REG_ADDR_W(5), .BRANCH_PENALTY(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if_id(s1), .bubble_id_ex(b1), .flush_if_id(f1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .stall_count(sc1), .flush_count(fc1)
  );

  // Instruction-level model: pipe[d][0]=EX, [1]=MEM, [2]=WB
  typedef struct {
    bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  ins_t pipe [2][3];
  int   fwin [2];
  int   scnt [2];
  int   fcnt [2];
  int   pen  [2] = '{2, 3};
  int   cmax [2] = '{65535, 3};

  function automatic ins_t id_ins();
    ins_t i;
    i.v = id_valid; i.rd = id_rd; i.rw = id_reg_write; i.mr = id_mem_read;
    i.rs1 = id_rs1; i.rs2 = id_rs2; i.u1 = id_uses_rs1; i.u2 = id_uses_rs2;
    return i;
  endfunction

  function automatic bit m_load_use(int d);
    ins_t p;
    p = pipe[d][0];
    return id_valid && p.v && p.mr && p.rw && p.rd != 0 &&
           ((id_uses_rs1 && id_rs1 == p.rd) || (id_uses_rs2 && id_rs2 == p.rd));
  endfunction

  // Distance to nearest older writer of the source: 1 = MEM (01), 2 = WB (10)
  function automatic int m_fwd(int d, bit use_b);
    ins_t c;
    int   r;
    c = pipe[d][0];
    if (!c.v || !(use_b ? c.u2 : c.u1)) return 0;
    r = use_b ? c.rs2 : c.rs1;
    for (int k = 1; k <= 2; k++)
      if (pipe[d][k].v && pipe[d][k].rw && pipe[d][k].rd != 0 && pipe[d][k].rd == r) return k;
    return 0;
  endfunction

  task automatic model_step();
    ins_t bub, nx;
    bit   fl, lu;
    bub = '{default: 0};
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int k = 0; k < 3; k++) pipe[d][k] = bub;
        fwin[d] = 0; scnt[d] = 0; fcnt[d] = 0;
      end else begin
        fl = ex_branch_taken || fwin[d] > 0;
        lu = m_load_use(d);
        nx = (fl || lu || !id_valid) ? bub : id_ins();
        if (lu && !fl && scnt[d] < cmax[d]) scnt[d]++;
        if (ex_branch_taken && fcnt[d] < cmax[d]) fcnt[d]++;
        fwin[d] = ex_branch_taken ? pen[d] - 1 : (fwin[d] > 0 ? fwin[d] - 1 : 0);
        pipe[d][2] = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = nx;
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit fl, lu;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_stall_count", d), d == 0 ? int'(sc0) : int'(sc1), scnt[d]);
      chk($sformatf("d%0d_flush_count", d), d == 0 ? int'(fc0) : int'(fc1), fcnt[d]);
      if (!reset) begin
        fl = ex_branch_taken || fwin[d] > 0;
        lu = m_load_use(d);
        chk($sformatf("d%0d_flush_if_id", d), d == 0 ? int'(f0) : int'(f1), int'(fl));
        chk($sformatf("d%0d_stall_if_id", d), d == 0 ? int'(s0) : int'(s1), int'(lu && !fl));
        chk($sformatf("d%0d_bubble_id_ex", d), d == 0 ? int'(b0) : int'(b1), int'(fl || lu));
        chk($sformatf("d%0d_fwd_a_sel", d), d == 0 ? int'(fa0) : int'(fa1), m_fwd(d, 1'b0));
        chk($sformatf("d%0d_fwd_b_sel", d), d == 0 ? int'(fb0) : int'(fb1), m_fwd(d, 1'b1));
      end
    end
  endtask

  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic set_id(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    nop();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) pipe[d][k] = '{default: 0};
      fwin[d] = 0; scnt[d] = 0; fcnt[d] = 0;
    end
    #1;
    adv();
    adv();
    reset = 1'b0;
    settle();
    chk("reset_flush", int'(f0 | f1), 0);
    chk("reset_fwd", int'({fa0, fb0, fa1, fb1}), 0);
    adv();

    // Back-to-back dependency
    set_id(1, 1, 2, 1, 1, 5, 1, 0);  cycle();           // add x5,x1,x2
    set_id(1, 5, 1, 1, 1, 6, 1, 0);  cycle();           // sub x6,x5,x1
    set_id(1, 3, 5, 1, 1, 9, 1, 0);  settle();          // or x9,x3,x5
    chk("b2b_fwd_a_mem", int'(fa0), 1);
    chk("b2b_fwd_b_rf", int'(fb0), 0);
    adv();
    nop(); settle();
    chk("b2b_fwd_b_wb", int'(fb0), 2);
    chk("b2b_fwd_a_rf", int'(fa0), 0);
    adv();

    // Load-use
    set_id(1, 2, 0, 1, 0, 7, 1, 1);  cycle();           // lw x7
    set_id(1, 7, 7, 1, 1, 8, 1, 0);  settle();          // add x8,x7,x7
    chk("lu_stall", int'(s0), 1);
    chk("lu_bubble", int'(b0), 1);
    adv();
    settle();
    chk("lu_stall_once", int'(s0), 0);
    adv();
    nop(); settle();
    chk("lu_fwd_a_wb", int'(fa0), 2);
    chk("lu_fwd_b_wb", int'(fb0), 2);
    chk("lu_stall_count", int'(sc0), 1);
    adv();

    // x0 never causes a hazard or forward
    set_id(1, 2, 0, 1, 0, 0, 1, 1);  cycle();           // lw x0
    set_id(1, 0, 0, 1, 1, 1, 1, 0);  settle();          // add x1,x0,x0
    chk("x0_no_stall", int'(s0), 0);
    adv();
    nop(); settle();
    chk("x0_fwd", int'({fa0, fb0}), 0);
    chk("x0_stall_count", int'(sc0), 1);
    adv();
    cycle(); cycle();

    // Branch flush windows: penalty 2 on dut0, 3 on dut1
    ex_branch_taken = 1'b1; settle();
    chk("br_c0", int'({f0, f1, b0, b1}), 4'b1111);
    adv();
    ex_branch_taken = 1'b0; settle();
    chk("br_c1", int'({f0, f1, b0, b1}), 4'b1111);
    adv();
    settle();
    chk("br_c2", int'({f0, f1}), 2'b01);
    adv();
    settle();
    chk("br_c3", int'({f0, f1}), 2'b00);
    chk("br_flush_count", int'(fc0), 1);
    adv();

    // Flush beats load-use
    set_id(1, 2, 0, 1, 0, 7, 1, 1);  cycle();           // lw x7
    set_id(1, 7, 0, 1, 0, 8, 1, 0);
    ex_branch_taken = 1'b1; settle();
    chk("prio_stall", int'(s0), 0);
    chk("prio_flush", int'(f0), 1);
    adv();
    ex_branch_taken = 1'b0; nop();
    cycle(); cycle();
    settle();
    chk("prio_stall_count", int'(sc0), 1);
    adv();

    // Reset in the middle of the dut1 flush window
    ex_branch_taken = 1'b1; cycle();
    ex_branch_taken = 1'b0; reset = 1'b1; cycle();
    reset = 1'b0; settle();
    chk("rst_mid_outs", int'({s1, b1, f1, fa1, fb1}), 0);
    chk("rst_mid_cnts", int'({sc0, fc0, sc1, fc1}), 0);
    adv();

    // Flush counter saturation on the 2-bit instance
    for (int n = 0; n < 5; n++) begin
      ex_branch_taken = 1'b1; cycle();
      ex_branch_taken = 1'b0; cycle();
    end
    settle();
    chk("sat_fc1", int'(fc1), 3);
    chk("sat_fc0", int'(fc0), 5);
    adv();

    // Randomised traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
             $urandom_range(0, 2) == 0);
      ex_branch_taken = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 59) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
